// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC channel: FSM state encoding, drop counter width, popcount.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HELD  = 2'd2
  } tdc_state_t;

  localparam int DROP_W  = 8;
  // Widest thermometer the popcount helper accepts; callers zero-extend.
  localparam int POP_MAX = 1024;

  function automatic logic [15:0] popcount(input logic [POP_MAX-1:0] v);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      c = c + 16'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/tdc_ts_fifo.sv
// Timestamp FIFO: 0-cycle head visibility after the write edge, push accepted when full if a pop
// happens the same cycle; pop on an empty FIFO and push on a full one without pop are ignored.
module tdc_ts_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_dat_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
  end

endmodule

// File: rtl/tdc_channel.sv
// Carry-chain TDC channel: hit-to-ts_valid latency 4 clocks; timestamps queue in a FIFO, overflow is counted in drop_cnt.
// Optional TDC_BUBBLE_FILTER_EN applies a 3-tap majority filter to the sampled thermometer code.
module tdc_channel
  import tdc_pkg::*;
#(
  parameter int LENGTH     = 128,
  parameter int FINE_W     = $clog2(LENGTH + 1),
  parameter int COARSE_W   = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hit,
  input  logic                en,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic [FINE_W-1:0]   ts_fine,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic                ts_sat,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int ENT_W = 1 + FINE_W + COARSE_W;

  // Sum bits fall 1->0 as the carry ripples; inverted they read as a thermometer code.
  (* keep *) logic [LENGTH-1:0] chain_w;
  assign chain_w = ~({LENGTH{1'b1}} + {{(LENGTH-1){1'b0}}, hit});

  logic [LENGTH-1:0] s1_q, s2_q, s2f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= chain_w;
      s2_q <= s1_q;
    end
  end

`ifdef TDC_BUBBLE_FILTER_EN
  for (genvar k = 0; k < LENGTH; k++) begin : g_maj
    logic lo, hi;
    if (k == 0) begin : g_lo_edge
      assign lo = 1'b1;
    end else begin : g_lo
      assign lo = s2_q[k-1];
    end
    if (k == LENGTH - 1) begin : g_hi_edge
      assign hi = 1'b0;
    end else begin : g_hi
      assign hi = s2_q[k+1];
    end
    assign s2f[k] = (lo & s2_q[k]) | (lo & hi) | (s2_q[k] & hi);
  end
`else
  assign s2f = s2_q;
`endif

  logic [COARSE_W-1:0] coarse_q, coarse_d;
  assign coarse_d = en ? coarse_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coarse_q <= '0;
    else        coarse_q <= coarse_d;
  end

  tdc_state_t          state_q;
  logic                enc_vld_q;
  logic [FINE_W-1:0]   enc_fine_q;
  logic                enc_sat_q;
  logic [COARSE_W-1:0] enc_coarse_q;

  // The ARMED->HELD transition is the event; encode results load on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      enc_vld_q    <= 1'b0;
      enc_fine_q   <= '0;
      enc_sat_q    <= 1'b0;
      enc_coarse_q <= '0;
    end else begin
      enc_vld_q <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE:  if (!s2_q[0]) state_q <= ARMED;
          ARMED: if (s2_q[0]) begin
            state_q      <= HELD;
            enc_vld_q    <= 1'b1;
            enc_fine_q   <= FINE_W'(popcount(POP_MAX'(s2f)));
            enc_sat_q    <= &s2f;
            enc_coarse_q <= coarse_q;
          end
          HELD:  if (!s2_q[0]) state_q <= ARMED;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic             fifo_full, fifo_empty, pop, accept;
  logic [ENT_W-1:0] head_dat;
  logic             head_sat;
  logic [FINE_W-1:0] head_fine;
  logic [COARSE_W-1:0] head_coarse;

  assign pop    = ts_valid && ts_ready;
  assign accept = !fifo_full || pop;

  tdc_ts_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (enc_vld_q),
    .push_dat_i ({enc_sat_q, enc_fine_q, enc_coarse_q}),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_dat_o (head_dat)
  );

  logic [DROP_W-1:0] drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      drop_q <= '0;
    else if (enc_vld_q && !accept && (drop_q != '1)) drop_q <= drop_q + 1'b1;
  end

  assign {head_sat, head_fine, head_coarse} = head_dat;

  // Outputs are gated so stale or unwritten storage never leaks out while empty.
  assign ts_valid  = !fifo_empty;
  assign ts_fine   = ts_valid ? head_fine   : '0;
  assign ts_coarse = ts_valid ? head_coarse : '0;
  assign ts_sat    = ts_valid ? head_sat    : 1'b0;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_tdc_channel.sv
// Bench for tdc_channel: table-driven single hits plus FIFO overflow, simultaneous push/pop, en re-arm and reset sequences.
module tb_tdc_channel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hit = 1'b0;
  logic        en = 1'b0;
  logic        ts_ready = 1'b0;
  logic        ts_valid;
  logic [7:0]  ts_fine;
  logic [23:0] ts_coarse;
  logic        ts_sat;
  logic [7:0]  drop_cnt;

  tdc_channel dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hit       (hit),
    .en        (en),
    .ts_valid  (ts_valid),
    .ts_ready  (ts_ready),
    .ts_fine   (ts_fine),
    .ts_coarse (ts_coarse),
    .ts_sat    (ts_sat),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  fine;
    logic        sat;
    logic [23:0] coarse;
  } exp_t;

  typedef struct {
    logic [127:0] taps;
    bit           use_hit;
    logic [7:0]   fine;
    bit           sat;
  } vec_t;

  exp_t         sb[$];
  exp_t         mon_e;
  vec_t         vecs[6];
  logic [23:0]  tb_cnt;
  logic [127:0] pat_v;
  int           seen;

  // Reference coarse counter: counts while en=1, zero otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= '0;
    else        tb_cnt <= en ? tb_cnt + 24'd1 : 24'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [127:0] ones(input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && ts_valid && ts_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got fine %0d coarse %0d expected no entry", ts_fine, ts_coarse);
      end else begin
        mon_e = sb.pop_front();
        check("pop_fine",   32'(ts_fine),   32'(mon_e.fine));
        check("pop_sat",    32'(ts_sat),    32'(mon_e.sat));
        check("pop_coarse", 32'(ts_coarse), 32'(mon_e.coarse));
      end
    end
  end

  // One hit occupying exactly 4 clock edges (N..N+3 relative to the s1 sample).
  task automatic pulse(input logic [127:0] pat, input bit use_hit, input bit expect_acc,
                       input logic [7:0] fine, input bit sat, input bit lat_chk, input bit rdy_at_wr);
    exp_t e;
    if (use_hit) hit = 1'b1;
    else begin
      pat_v = pat;
      force dut.chain_w = pat_v;
    end
    @(posedge clk); #1;
    if (use_hit) hit = 1'b0;
    else release dut.chain_w;
    @(posedge clk); #1;
    e.fine   = fine;
    e.sat    = sat;
    e.coarse = tb_cnt;
    if (expect_acc) sb.push_back(e);
    @(posedge clk); #1;
    if (rdy_at_wr) ts_ready = 1'b1;
    if (lat_chk) check("lat_early_valid", 32'(ts_valid), 32'd0);
    @(posedge clk); #1;
    if (rdy_at_wr) ts_ready = 1'b0;
    if (lat_chk) check("lat_4_valid", 32'(ts_valid), 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    check("drain_empty_sb", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    check("drain_valid_low", 32'(ts_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{ones(37),   1'b0, 8'd37,  1'b0};
    vecs[1] = '{'0,         1'b1, 8'd128, 1'b1};
    vecs[2] = '{ones(1),    1'b0, 8'd1,   1'b0};
    vecs[3] = '{ones(127),  1'b0, 8'd127, 1'b0};
`ifdef TDC_BUBBLE_FILTER_EN
    vecs[4] = '{128'h37,    1'b0, 8'd6,   1'b0};
`else
    vecs[4] = '{128'h37,    1'b0, 8'd5,   1'b0};
`endif
    vecs[5] = '{ones(64),   1'b0, 8'd64,  1'b0};

    #2;
    check("rst_valid",  32'(ts_valid),  32'd0);
    check("rst_fine",   32'(ts_fine),   32'd0);
    check("rst_coarse", 32'(ts_coarse), 32'd0);
    check("rst_sat",    32'(ts_sat),    32'd0);
    check("rst_drop",   32'(drop_cnt),  32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1'b1;
    ts_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      pulse(vecs[i].taps, vecs[i].use_hit, 1'b1, vecs[i].fine, vecs[i].sat, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
    end
    check("vec_sb_empty", 32'(sb.size()), 32'd0);

    // Overflow: 6 hits into a 4-deep FIFO with the consumer stalled.
    ts_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse(ones(10 + i), 1'b0, (i < 4), 8'(10 + i), 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("ovf_drop",      32'(drop_cnt),  32'd2);
    check("ovf_valid",     32'(ts_valid),  32'd1);
    check("hold_fine_1",   32'(ts_fine),   32'(sb[0].fine));
    @(negedge clk);
    check("hold_fine_2",   32'(ts_fine),   32'(sb[0].fine));
    check("hold_coarse_2", 32'(ts_coarse), 32'(sb[0].coarse));
    @(posedge clk); #1;
    ts_ready = 1'b1;
    wait_drain();
    check("ovf_drop_after", 32'(drop_cnt), 32'd2);

    // Full FIFO, write coinciding with a pop.
    ts_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse(ones(20 + i), 1'b0, 1'b1, 8'(20 + i), 1'b0, 1'b0, 1'b0);
    end
    pulse(ones(30), 1'b0, 1'b1, 8'd30, 1'b0, 1'b0, 1'b1);
    check("simul_drop",  32'(drop_cnt), 32'd2);
    check("simul_head",  32'(ts_fine),  32'd21);
    @(posedge clk); #1;
    ts_ready = 1'b1;
    wait_drain();

    // hit held high while en rises: no event until a low sample.
    en = 1'b0;
    hit = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    en = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ts_valid) seen++;
    end
    check("en_hold_no_event", 32'(seen), 32'd0);
    hit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pulse('0, 1'b1, 1'b1, 8'd128, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("en_rearm_sb_empty", 32'(sb.size()), 32'd0);

    // Reset pulsed while draining.
    ts_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse(ones(40 + i), 1'b0, 1'b1, 8'(40 + i), 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    ts_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #3;
    check("pre_rst_valid", 32'(ts_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  32'(ts_valid),  32'd0);
    check("mid_rst_fine",   32'(ts_fine),   32'd0);
    check("mid_rst_coarse", 32'(ts_coarse), 32'd0);
    check("mid_rst_sat",    32'(ts_sat),    32'd0);
    check("mid_rst_drop",   32'(drop_cnt),  32'd0);
    sb.delete();
    ts_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(ts_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdc_channel.md
# tdc_channel

Single-channel time-to-digital converter front end built around a parametrised carry-chain delay line. The block launches the asynchronous `hit` edge down a LENGTH-tap carry chain, samples the thermometer code every `clk`, detects a new hit, and encodes it into a fine (tap count) and coarse (cycle counter) timestamp. Timestamps are buffered in a small FIFO behind a valid/ready handshake. It sits between the pad-level hit input and the readout/serialiser logic.

## Interface
- `LENGTH`, 128: carry-chain taps. Must be ≥ 4.
- `FINE_W`, `$clog2(LENGTH+1)`: fine timestamp width.
- `COARSE_W`, 24: coarse counter width.
- `FIFO_DEPTH`, 4: timestamp FIFO entries. Must be a power of 2, ≥ 2.

- `clk`: input, 1. Sampling clock.
- `rst_n`: input, 1. Asynchronous, active-low reset.
- `hit`: input, 1. Asynchronous hit; drives the carry-chain carry-in.
- `en`: input, 1. Channel enable.
- `ts_valid`: output, 1. FIFO head valid.
- `ts_ready`: input, 1. Consumer accepts the head.
- `ts_fine`: output, FINE_W. Ones count of the captured sample, 1..LENGTH.
- `ts_coarse`: output, COARSE_W. Coarse count at the capture sample.
- `ts_sat`: output, 1. All LENGTH taps were set: fine value saturated.
- `drop_cnt`: output, 8. Saturating count of hits lost to FIFO full.

## Operation
- Chain: constant all-ones plus `hit`, LENGTH bits, with the synthesis keep attribute so the carry chain is preserved. Tap k reads 1 once the edge has passed tap k, forming a thermometer code.
- Sampling: two flop stages, `s1` then `s2`, on every `clk`, both regardless of `en`.
- Coarse counter: increments every cycle while `en`=1 and wraps from 2^COARSE_W−1 to 0. It is held at 0 while `en`=0.
- FSM, with states IDLE, ARMED and HELD:
  - IDLE → ARMED when `en`=1 and `s2[0]`=0.
  - ARMED → HELD when `s2[0]`=1. This is the event: capture `s2` and the coarse count.
  - HELD → ARMED when `s2[0]`=0, which re-arms the channel.
  - Any state → IDLE when `en`=0.
  - If `s2[0]`=1 when leaving IDLE, the FSM waits for a low sample first, so no stale event is produced.
- Encode:
  - Register the popcount of the captured sample, pipelined in one stage.
  - `ts_sat`=1 iff all taps are 1; `ts_fine` is then LENGTH.
- FIFO write:
  - A write is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the hit is dropped and `drop_cnt` increments, saturating at 255.
- Pop: occurs on `ts_valid & ts_ready`. The outputs hold steady while `ts_valid`=1 and `ts_ready`=0.
- Effect of `en`=0: the FSM only is forced to IDLE. FIFO contents remain drainable. An event already in the encode pipeline completes.
- Reset (asynchronous, any time):
  - FSM → IDLE; `s1`, `s2`, coarse counter, pipeline and FIFO cleared.
  - `ts_valid`=0, `ts_fine`=0, `ts_coarse`=0, `ts_sat`=0, `drop_cnt`=0.

## Timing
- Hit sampled into `s1` at edge N, `s2` at N+1. The event is detected on `s2`, and its encode register loads at N+2.
- FIFO write at N+3. With the FIFO empty, `ts_valid`=1 in the cycle after edge N+3. Hit-to-valid latency is 4 cycles.
- `ts_coarse` equals the counter value at edge N+1, when `s2` was loaded.
- Minimum hit spacing is 2 `s2` samples (high, then low). A narrower low gap merges into a single event.
- Throughput is 1 timestamp per 2 cycles maximum. The FIFO absorbs bursts.
- `ts_ready` may be asserted without `ts_valid`; this has no effect.

## Configuration
- `TDC_BUBBLE_FILTER_EN` defined:
  - Each tap k of `s2` is replaced by the majority of taps k−1, k, k+1 before capture and popcount.
  - Edge taps use k−1:=1 at tap 0 and k+1:=0 at the last tap.
  - The filter is combinational; latency is unchanged.
- Undefined: the raw `s2` is used. Bubbles then shift the count directly.

## Structure
- Package `tdc_pkg` holds:
  - The FSM state enum `tdc_state_t` (IDLE, ARMED, HELD).
  - The `DROP_W`=8 constant.
  - A popcount function.
- Sub-module `tdc_ts_fifo`: synchronous FIFO, parametrised by width and depth, with full/empty flags and simultaneous push/pop supported.
- Chain, sampling, FSM, coarse counter and encoder live in `tdc_channel`.

## Test plan
- Reset, then `en`=1 and a single `hit` rise with the model chain giving 37 taps set → after 4 cycles `ts_valid`=1, `ts_fine`=37, `ts_sat`=0, `ts_coarse` = counter at the `s2` load.
- A hit with all 128 taps set → `ts_fine`=128, `ts_sat`=1.
- `ts_ready`=0 with 6 hits spaced 4 cycles apart, FIFO_DEPTH=4 → 4 entries held, `drop_cnt`=2; then draining `ts_ready`=1 returns the 4 entries in order.
- FIFO full and a write coinciding with a pop → the write is accepted and `drop_cnt` is unchanged.
- `hit` held high across `en` 0→1 → no event until a low sample, then the next rise is captured.
- Sample with a bubble pattern 1110110000…:
  - With `TDC_BUBBLE_FILTER_EN` → `ts_fine`=6.
  - Without it → `ts_fine`=5.
  - Then `rst_n` pulsed mid-drain → all outputs are 0 immediately.
